bram_arb_ctrl: RTL
==================

# bram_arb_ctrl

Parametrised multi-channel BRAM port controller: arbitrates NCH independent PL request channels onto a single native BRAM port, issuing one access per cycle with byte-lane write enables. It returns read data or write acknowledges to the originating channel after a fixed, parameter-defined latency. It sits between PL datapath masters and a Block Memory Generator port and supersedes the single-master BRAM bridge.

## Interface
- DATA_W, 32, data width in bits; multiple of 8, ≥ 8
- ADDR_W, 32, byte address width
- NCH, 2, number of request channels, 1..8
- RD_LAT, 1, BRAM read latency in cycles, 1 or 2
- clk  in  1  single clock for all logic
- rst  in  1  asynchronous, active-high reset
- en  in  1  global issue enable; low blocks new grants, in-flight accesses drain
- req_valid  in  NCH  per-channel request valid
- req_ready  out  NCH  per-channel grant, at most one bit high
- req_we  in  NCH*DATA_W/8  byte write enables per channel; all-zero = read
- req_addr  in  NCH*ADDR_W  byte address per channel
- req_wdata  in  NCH*DATA_W  write data per channel
- rsp_valid  out  NCH  one-hot response strobe, no backpressure
- rsp_rdata  out  DATA_W  response data, shared by all channels
- bram_clk  out  1  equals clk
- bram_rst  out  1  registered copy of rst
- bram_en, bram_we (DATA_W/8), bram_addr (ADDR_W), bram_wdata (DATA_W)  out  BRAM command
- bram_rdata  in  DATA_W  BRAM read data

## Operation
- Round-robin arbiter: req_ready is combinational from req_valid, en and the priority pointer. The lowest index at or after the pointer with req_valid high is granted. No grants while en=0 or rst=1.
- Accept = req_valid[i] & req_ready[i]. On accept, the pointer moves to i+1 mod NCH; otherwise it holds.
- Accepted command is registered onto the BRAM port. bram_addr is req_addr with its low log2(DATA_W/8) bits forced to 0. bram_we = req_we. bram_en=1 for exactly one cycle per accept.
- A tag pipeline carries valid plus channel id through RD_LAT+1 stages. Its output drives rsp_valid (one-hot) and registers bram_rdata into rsp_rdata.
- Every access (read or write) produces exactly one response. For writes, rsp_rdata equals bram_rdata as returned by the BRAM and is don't-care to the master.
- When idle: bram_en=0, bram_we=0. bram_addr and bram_wdata hold their last values.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, bram_en=0, bram_we=0, bram_addr=0, bram_wdata=0, bram_rst=1, pointer=0, tag pipeline empty.
- Cycle 0: accept. Cycle 1: bram_en=1. Cycle 1+RD_LAT: bram_rdata valid. Cycle 2+RD_LAT: rsp_valid=1 with rsp_rdata.
- Throughput: one accept per cycle sustained. Back-to-back accepts yield back-to-back responses in issue order.
- en falling: no accept in that cycle. Accesses already accepted still complete and respond.
- Reset asserted mid-operation: pipeline cleared, so in-flight responses are dropped. All outputs return to reset values immediately.
- Reset deasserted: bram_rst falls one edge later. The first grant is possible in the first cycle with rst=0.
- A single requester stays granted every cycle. Wrap: pointer NCH-1 → 0.

## Structure
- Package bram_ctrl_pkg holds:
  - function clog2
  - CH_W = max(1, clog2(NCH))
  - BE_W = DATA_W/8
  - the tag record (valid, ch id)
- One sub-module, rr_arbiter, parametrised by NCH: request vector, advance strobe → one-hot grant, registered pointer. Same clk/rst.

## Test plan
- Single read: ch0 reads 0x0000_0013, BRAM holds 0xDEADBEEF at 0x10 → bram_addr=0x10 in cycle 1; rsp_valid=2'b01, rsp_rdata=0xDEADBEEF in cycle 3 (RD_LAT=1), cycle 4 (RD_LAT=2).
- Byte write: ch1 we=4'b0011, wdata=0x1122_3344 @0x20, then read @0x20 over prior 0xFFFF_FFFF → ack rsp_valid=2'b10; readback 0xFFFF_3344.
- Fairness: ch0 and ch1 valid continuously for 8 cycles → grants alternate 0,1,0,1…; 4 responses each, in issue order.
- Stall: en low for 3 cycles mid-stream → no req_ready, no bram_en during stall; already accepted responses still arrive.
- Reset mid-flight: rst pulsed the cycle after an accept → no rsp_valid for that access; all outputs at reset values; pointer restarts at 0.
- NCH=4 wrap: ch3 granted with all valid → next grant ch0.

Source files
------------

// File: rtl/bram_ctrl_pkg.sv
// Shared types and helpers for the multi-channel BRAM port controller.
package bram_ctrl_pkg;

   localparam int TAG_CH_W = 3;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

   function automatic int ch_w(input int nch);
      return (clog2(nch) > 1) ? clog2(nch) : 1;
   endfunction

   function automatic int be_w(input int data_w);
      return data_w / 8;
   endfunction

   // Wide enough for the largest supported channel count (8).
   typedef struct packed {
      logic                valid;
      logic [TAG_CH_W-1:0] ch;
   } tag_t;

endpackage

// File: rtl/bram_arb_ctrl_if.sv
// Request/response channels plus native BRAM port of the controller.
interface bram_arb_ctrl_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int NCH    = 2
);
   localparam int BE_W = DATA_W / 8;

   logic                   en;
   logic [NCH-1:0]         req_valid;
   logic [NCH-1:0]         req_ready;
   logic [NCH*BE_W-1:0]    req_we;
   logic [NCH*ADDR_W-1:0]  req_addr;
   logic [NCH*DATA_W-1:0]  req_wdata;
   logic [NCH-1:0]         rsp_valid;
   logic [DATA_W-1:0]      rsp_rdata;
   logic                   bram_clk;
   logic                   bram_rst;
   logic                   bram_en;
   logic [BE_W-1:0]        bram_we;
   logic [ADDR_W-1:0]      bram_addr;
   logic [DATA_W-1:0]      bram_wdata;
   logic [DATA_W-1:0]      bram_rdata;

   modport master (
      output en, req_valid, req_we, req_addr, req_wdata, bram_rdata,
      input  req_ready, rsp_valid, rsp_rdata, bram_clk, bram_rst, bram_en, bram_we,
             bram_addr, bram_wdata
   );

   modport slave (
      input  en, req_valid, req_we, req_addr, req_wdata, bram_rdata,
      output req_ready, rsp_valid, rsp_rdata, bram_clk, bram_rst, bram_en, bram_we,
             bram_addr, bram_wdata
   );
endinterface

// File: rtl/bram_arb_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, registered priority pointer.
module rr_arbiter
   import bram_ctrl_pkg::*;
#(
   parameter int NCH = 2,
   localparam int CH_W = ch_w(NCH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_en,
   input  logic [NCH-1:0]  i_req,
   input  logic            i_adv,
   output logic [NCH-1:0]  o_gnt,
   output logic [CH_W-1:0] o_gnt_idx
);

   logic [CH_W-1:0] r_ptr;
   logic [CH_W-1:0] w_ptr_nxt;
   logic            w_found;
   int              w_idx;

   // Scan from the pointer upward with wrap; first requester wins.
   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      w_found   = 1'b0;
      w_idx     = 0;
      for (int k = 0; k < NCH; k++) begin
         w_idx = int'(r_ptr) + k;
         if (w_idx >= NCH) w_idx = w_idx - NCH;
         if (!w_found && i_en && !rst && i_req[w_idx]) begin
            w_found      = 1'b1;
            o_gnt[w_idx] = 1'b1;
            o_gnt_idx    = CH_W'(w_idx);
         end
      end
   end

   assign w_ptr_nxt = (o_gnt_idx == CH_W'(NCH - 1)) ? '0 : o_gnt_idx + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr <= '0;
      end else if (i_adv) begin
         r_ptr <= w_ptr_nxt;
      end
   end

endmodule

// File: rtl/bram_arb_ctrl.sv
// Arbitrates NCH request channels onto one BRAM port; responses return after RD_LAT+2 cycles.
module bram_arb_ctrl
   import bram_ctrl_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int NCH    = 2,
   parameter int RD_LAT = 1
) (
   input  logic           clk,
   input  logic           rst,
   bram_arb_ctrl_if.slave bus
);

   localparam int BE_W = be_w(DATA_W);
   localparam int CH_W = ch_w(NCH);
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(BE_W - 1);

   logic [NCH-1:0]    w_gnt;
   logic [CH_W-1:0]   w_ch;
   logic              w_accept;
   logic [BE_W-1:0]   w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;
   tag_t              w_last;
   logic [NCH-1:0]    w_rsp_onehot;

   logic              r_bram_rst;
   logic              r_bram_en;
   logic [BE_W-1:0]   r_bram_we;
   logic [ADDR_W-1:0] r_bram_addr;
   logic [DATA_W-1:0] r_bram_wdata;
   tag_t              r_tag [RD_LAT+1];
   logic [NCH-1:0]    r_rsp_valid;
   logic [DATA_W-1:0] r_rsp_rdata;

   rr_arbiter #(.NCH(NCH)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .i_en      (bus.en),
      .i_req     (bus.req_valid),
      .i_adv     (w_accept),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_ch)
   );

   assign w_accept    = |(bus.req_valid & w_gnt);
   assign w_sel_we    = bus.req_we[int'(w_ch)*BE_W +: BE_W];
   assign w_sel_addr  = bus.req_addr[int'(w_ch)*ADDR_W +: ADDR_W];
   assign w_sel_wdata = bus.req_wdata[int'(w_ch)*DATA_W +: DATA_W];
   assign w_last      = r_tag[RD_LAT];

   always_comb begin
      w_rsp_onehot = '0;
      if (w_last.valid) w_rsp_onehot[w_last.ch[CH_W-1:0]] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bram_rst <= 1'b1;
      end else begin
         r_bram_rst <= 1'b0;
      end
   end

   // Address and write data hold between accesses; only enables drop when idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bram_en    <= 1'b0;
         r_bram_we    <= '0;
         r_bram_addr  <= '0;
         r_bram_wdata <= '0;
      end else if (w_accept) begin
         r_bram_en    <= 1'b1;
         r_bram_we    <= w_sel_we;
         r_bram_addr  <= w_sel_addr & ADDR_MASK;
         r_bram_wdata <= w_sel_wdata;
      end else begin
         r_bram_en <= 1'b0;
         r_bram_we <= '0;
      end
   end

   // Stage 0 lines up with bram_en; stage RD_LAT lines up with valid bram_rdata.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k <= RD_LAT; k++) r_tag[k] <= '0;
         r_rsp_valid <= '0;
         r_rsp_rdata <= '0;
      end else begin
         r_tag[0].valid <= w_accept;
         r_tag[0].ch    <= TAG_CH_W'(w_ch);
         for (int k = 1; k <= RD_LAT; k++) r_tag[k] <= r_tag[k-1];
         r_rsp_valid <= w_rsp_onehot;
         if (w_last.valid) r_rsp_rdata <= bus.bram_rdata;
      end
   end

   assign bus.req_ready  = w_gnt;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_rdata  = r_rsp_rdata;
   assign bus.bram_clk   = clk;
   assign bus.bram_rst   = r_bram_rst;
   assign bus.bram_en    = r_bram_en;
   assign bus.bram_we    = r_bram_we;
   assign bus.bram_addr  = r_bram_addr;
   assign bus.bram_wdata = r_bram_wdata;

endmodule
